// File: rtl/shift_pla_pipe.sv
// shift_pla_pipe: three-stage elastic pipeline that approximates tanh(x) or
// sigmoid(x) with a shift-and-add piecewise-linear approximation.
//   S1: |x| with one extra integer bit (halved in sigmoid mode), split k/f
//   S2: m = 1 - 2^(-2k)*(1 - f/2 - f/4) with 2 guard bits, saturation detect
//   S3: sign / sigmoid offset, registered outputs
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   in_valid/in_ready       input handshake; in_data (signed Q IN_I.IN_F), in_mode (0 tanh, 1 sigmoid)
//   out_valid/out_ready     output handshake; out_data (signed Q1.OUT_F), out_sat
//   sat_count               16-bit saturating count of saturated output transfers
//                           (present only when SHIFT_PLA_PIPE_SAT_CNT_EN is defined)
module shift_pla_pipe #(
  parameter int W_IN  = 8,
  parameter int IN_I  = 4,
  parameter int W_OUT = 8,
  parameter int SAT_K = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_sat
`ifdef SHIFT_PLA_PIPE_SAT_CNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  localparam int IN_F  = W_IN - IN_I;
  localparam int OUT_F = W_OUT - 1;
  localparam int G     = OUT_F + 2;   // working fraction bits (2 guard bits)
  localparam int MW    = G + 2;       // room for 1.0 plus headroom
  localparam int AW    = W_IN + 1;    // magnitude with one extra integer bit
  localparam int KW    = IN_I + 1;

  // Stage enables: a stage loads when empty or when its contents move on.
  logic en1, en2, en3;
  logic s1_valid, s2_valid;

  assign en3      = !out_valid || out_ready;
  assign en2      = !s2_valid || en3;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1 && !reset;

  // ---------------- S1: absolute value and integer/fraction split
  logic [AW-1:0]   x_ext, a_abs, a_sel;
  logic [KW-1:0]   s1_k;
  logic [IN_F-1:0] s1_f;
  logic            s1_neg, s1_mode;

  always_comb begin
    x_ext = {in_data[W_IN-1], in_data};
    if (in_data[W_IN-1]) a_abs = ~x_ext + {{(AW-1){1'b0}}, 1'b1};
    else                 a_abs = x_ext;
    // Sigmoid uses |x|/2; the bit shifted out is simply dropped.
    if (in_mode) a_sel = a_abs >> 1;
    else         a_sel = a_abs;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_f     <= '0;
      s1_neg   <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_k    <= a_sel[AW-1:IN_F];
        s1_f    <= a_sel[IN_F-1:0];
        s1_neg  <= in_data[W_IN-1];
        s1_mode <= in_mode;
      end
    end
  end

  // ---------------- S2: shift/PLA magnitude and saturation
  logic [IN_F+G-1:0] f_wide;
  logic [MW-1:0]     one_g, f_g, t_g, p_g, m_g;
  logic [OUT_F-1:0]  m_next, s2_m;
  logic              sat_next, s2_sat, s2_neg, s2_mode;

  always_comb begin
    one_g  = {{(MW-G-1){1'b0}}, 1'b1, {G{1'b0}}};
    // Re-align f from IN_F fraction bits to G fraction bits.
    f_wide = {s1_f, {G{1'b0}}} >> IN_F;
    f_g    = {{(MW-G){1'b0}}, f_wide[G-1:0]};
    t_g    = one_g - (f_g >> 1) - (f_g >> 2);
    p_g    = t_g >> {s1_k, 1'b0};           // 2^(-2k) as a right shift by 2k
    m_g    = one_g - p_g;                   // always < 1.0 since t > 0.25
    sat_next = (s1_k >= KW'(SAT_K));
    if (sat_next) m_next = {OUT_F{1'b1}};
    else          m_next = m_g[G-1:2];      // drop guard bits (truncate)
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_m     <= '0;
      s2_sat   <= 1'b0;
      s2_neg   <= 1'b0;
      s2_mode  <= 1'b0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_m    <= m_next;
        s2_sat  <= sat_next;
        s2_neg  <= s1_neg;
        s2_mode <= s1_mode;
      end
    end
  end

  // ---------------- S3: sign / sigmoid offset and output registers
  logic [W_OUT-1:0] m_ext, tanh_val, res_next;
  logic [W_OUT:0]   half_one, sig_sum;

  always_comb begin
    m_ext    = {1'b0, s2_m};
    half_one = {2'b01, {OUT_F{1'b0}}};      // 1.0; halved below gives 0.5 + m/2
    if (s2_neg) begin
      tanh_val = ~m_ext + {{(W_OUT-1){1'b0}}, 1'b1};
      sig_sum  = half_one - {2'b00, s2_m};
    end else begin
      tanh_val = m_ext;
      sig_sum  = half_one + {2'b00, s2_m};
    end
    if (s2_mode) res_next = sig_sum[W_OUT:1];
    else         res_next = tanh_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en3) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= res_next;
        out_sat  <= s2_sat;
      end
    end
  end

`ifdef SHIFT_PLA_PIPE_SAT_CNT_EN
  // Count saturated output transfers; a stalled result is counted only on transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      sat_count <= 16'h0000;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/shift_pla_pipe.md
SHIFT_PLA_PIPE -- requirements
Module: shift_pla_pipe

Interface
REQ-001 Parameter W_IN, default 8: input wordlength; input is signed two's-complement fixed point.
REQ-002 Parameter IN_I, default 4: input integer bits, sign included; IN_F = W_IN-IN_I fractional bits, IN_F >= 2.
REQ-003 Parameter W_OUT, default 8: output wordlength; signed, 1 sign bit, OUT_F = W_OUT-1 fractional bits.
REQ-004 Parameter SAT_K, default 4: integer magnitude at or above which the output saturates.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_data/in_mode valid this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  W_IN  operand x.
REQ-010 in_mode  input  1  0 = tanh, 1 = sigmoid; travels with its sample.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 out_data  output  W_OUT  approximation result.
REQ-014 out_sat  output  1  result was forced to a saturation bound.

Function
REQ-015 A transfer occurs on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-016 The block is a 3-stage elastic pipeline (S1 abs/split, S2 shift/PLA, S3 sign/saturate/output register); a stage loads when it is empty or its contents advance in the same cycle.
REQ-017 in_ready is 1 when S1 is empty or S1 advances this cycle; it may depend combinationally on out_ready.
REQ-018 Latency is 3 cycles from input transfer to out_valid with out_ready held high; throughput is 1 sample/cycle.
REQ-019 out_data, out_sat and out_valid are driven directly from S3 registers and remain stable while out_valid && !out_ready.
REQ-020 S1 computes a = |x| with one extra integer bit, so the most negative input yields a positive magnitude; in sigmoid mode a = |x|>>1, and the LSB shifted out is discarded.
REQ-021 a is split into k = integer part and f = fractional part, 0 <= f < 1.
REQ-022 Magnitude: m = 1 - 2^(-2k)*(1 - f/2 - f/4), computed using shifts and adds only, with 2 guard bits below OUT_F.
REQ-023 m is truncated toward zero to OUT_F bits.
REQ-024 Saturation: if k >= SAT_K, m = 1 - 2^-OUT_F and out_sat = 1; otherwise out_sat = 0.
REQ-025 tanh mode: out_data = m for x >= 0, and the two's-complement negation of m for x < 0.
REQ-026 Sigmoid mode: out_data = 0.5 + m/2 for x >= 0 and 0.5 - m/2 for x < 0, truncated to OUT_F bits, always non-negative.
REQ-027 Samples with different in_mode may be interleaved back-to-back; each result uses its own sample's mode.
REQ-028 A simultaneous input and output transfer with all stages full is legal and loses no sample.

Reset
REQ-029 While reset is high at a clock edge, all stage valids clear, out_valid = 0, out_data = 0, and out_sat = 0.
REQ-030 in_ready is 0 during reset; in-flight samples at reset assertion are discarded without producing output.
REQ-031 The first input transfer is possible in the first cycle after reset deasserts.

Configuration
REQ-032 Macro SHIFT_PLA_PIPE_SAT_CNT_EN, when defined, adds output port sat_count (16 bits): counts output transfers with out_sat = 1, saturates at 0xFFFF, and is cleared by reset.
REQ-033 Without SHIFT_PLA_PIPE_SAT_CNT_EN, port sat_count and its logic are absent; all other behaviour is identical.

Verification (defaults W_IN=8, IN_I=4, W_OUT=8, SAT_K=4)
REQ-034 tanh, in_data 0x10 (1.0) -> out_data 0x60; 0xF0 (-1.0) -> 0xA0; 0x00 -> 0x00; 0x08 (0.5) -> 0x30; each 3 cycles after acceptance.
REQ-035 tanh, in_data 0x50 (5.0) -> 0x7F with out_sat=1; 0x80 (-8.0) -> 0x81 with out_sat=1.
REQ-036 sigmoid, in_data 0x20 (2.0) -> 0x70; 0xE0 (-2.0) -> 0x10; 0x00 -> 0x40; alternate tanh/sigmoid every cycle -> each result matches its own mode.
REQ-037 Stream 10 samples with out_ready low for cycles 4-7 -> in_ready drops once all stages are full, no sample lost or duplicated, and out_data holds stable while stalled.
REQ-038 Assert reset for 1 cycle with 3 samples in flight -> out_valid=0 the next cycle, none of those samples appears, and sat_count=0 when the macro is defined.
REQ-039 With SHIFT_PLA_PIPE_SAT_CNT_EN defined, 5 saturating transfers -> sat_count=5; a stalled saturated result is counted once.
